// File: rtl/bgd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bgd_pkg
// Desc     : Shared widths, shadow-stage type and saturation helper for BGD
// Revision : 1.0 - initial release
// ============================================================================
package bgd_pkg;

    localparam int c_data_width = 15;
    localparam int c_acc_width  = 24;

    localparam logic signed [c_acc_width-1:0] c_sat_max =
        {{(c_acc_width-c_data_width+1){1'b0}}, {(c_data_width-1){1'b1}}};
    localparam logic signed [c_acc_width-1:0] c_sat_min =
        {{(c_acc_width-c_data_width+1){1'b1}}, {(c_data_width-1){1'b0}}};

    typedef struct packed {
        logic vld;
        logic last;
    } shadow_t;

    // Returns {clipped, data}.
    function automatic logic [c_data_width:0] sat_to_data(input logic signed [c_acc_width-1:0] val);
        logic [c_data_width:0] res;
        if (val > c_sat_max) begin
            res = {1'b1, c_sat_max[c_data_width-1:0]};
        end else if (val < c_sat_min) begin
            res = {1'b1, c_sat_min[c_data_width-1:0]};
        end else begin
            res = {1'b0, val[c_data_width-1:0]};
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bgd_valid_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bgd_valid_pipe
// Desc     : ce-gated {vld, last} shift register tracking multiplier contents
// Revision : 1.0 - initial release
// ============================================================================
module bgd_valid_pipe
    import bgd_pkg::*;
#(
    parameter int DEPTH = 3
)(
    input  logic clk,
    input  logic rst,
    input  logic i_ce,
    input  logic i_vld,
    input  logic i_last,
    output logic o_vld,
    output logic o_last
);

    shadow_t r_pipe [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_pipe[i] <= '0;
            end
        end else if (i_ce) begin
            r_pipe[0] <= '{vld: i_vld, last: i_last};
            for (int i = 1; i < DEPTH; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign o_vld  = r_pipe[DEPTH-1].vld;
    assign o_last = r_pipe[DEPTH-1].last;

endmodule
`default_nettype wire

// File: rtl/bgd_dot_accum.sv
`default_nettype none
// ============================================================================
// Module   : bgd_dot_accum
// Desc     : Feeds an external pipelined multiplier and accumulates a dot product
// Revision : 1.0 - initial release
// ============================================================================
module bgd_dot_accum
    import bgd_pkg::*;
#(
    parameter int DATA_WIDTH  = c_data_width,
    parameter int ACC_WIDTH   = c_acc_width,
    parameter int MUL_LATENCY = 3,
    parameter int CNT_WIDTH   = 8
)(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_last,
    output logic                  mul_ce,
    output logic [DATA_WIDTH-1:0] mul_din0,
    output logic [DATA_WIDTH-1:0] mul_din1,
    input  logic [DATA_WIDTH-1:0] mul_dout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0]  out_count,
    output logic                  out_sat
);

    logic                        w_stall;
    logic                        w_tail_vld;
    logic                        w_tail_last;
    logic                        w_arrive;
    logic                        w_clip;
    logic [DATA_WIDTH-1:0]       w_sat_data;
    logic signed [ACC_WIDTH-1:0] r_acc;
    logic signed [ACC_WIDTH-1:0] w_sum;
    logic [CNT_WIDTH-1:0]        r_cnt;
    logic [CNT_WIDTH-1:0]        w_cnt_next;

    // A held result freezes the multiplier and its shadow together.
    assign w_stall  = out_valid & ~out_ready;
    assign mul_ce   = ~w_stall;
    assign in_ready = ~w_stall;
    assign mul_din0 = in_a;
    assign mul_din1 = in_b;

    bgd_valid_pipe #(
        .DEPTH (MUL_LATENCY)
    ) u_valid_pipe (
        .clk    (clk),
        .rst    (reset),
        .i_ce   (mul_ce),
        .i_vld  (in_valid & in_ready),
        .i_last (in_last),
        .o_vld  (w_tail_vld),
        .o_last (w_tail_last)
    );

    assign w_arrive   = w_tail_vld & mul_ce;
    assign w_sum      = r_acc + {{(ACC_WIDTH-DATA_WIDTH){mul_dout[DATA_WIDTH-1]}}, mul_dout};
    assign w_cnt_next = r_cnt + 1'b1;

    generate
        if (DATA_WIDTH == c_data_width && ACC_WIDTH == c_acc_width) begin : g_pkg_sat
            assign {w_clip, w_sat_data} = sat_to_data(w_sum);
        end else begin : g_param_sat
            localparam logic signed [ACC_WIDTH-1:0] c_max =
                {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
            localparam logic signed [ACC_WIDTH-1:0] c_min =
                {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
            always_comb begin
                w_clip     = 1'b1;
                w_sat_data = c_max[DATA_WIDTH-1:0];
                if (w_sum < c_min) begin
                    w_sat_data = c_min[DATA_WIDTH-1:0];
                end else if (w_sum <= c_max) begin
                    w_clip     = 1'b0;
                    w_sat_data = w_sum[DATA_WIDTH-1:0];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_count <= '0;
            out_sat   <= 1'b0;
            r_acc     <= '0;
            r_cnt     <= '0;
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // A last arrival overrides the clear above, giving back-to-back results.
            if (w_arrive) begin
                if (w_tail_last) begin
                    out_data  <= w_sat_data;
                    out_count <= w_cnt_next;
                    out_sat   <= w_clip;
                    out_valid <= 1'b1;
                    r_acc     <= '0;
                    r_cnt     <= '0;
                end else begin
                    r_acc     <= w_sum;
                    r_cnt     <= w_cnt_next;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bgd_dot_accum.sv
`default_nettype none
// ============================================================================
// Module   : tb_bgd_dot_accum
// Desc     : Self-checking bench with multiplier model and running-sum reference
// Revision : 1.0 - initial release
// ============================================================================
module tb_bgd_dot_accum;

    typedef struct packed {
        logic [14:0] data;
        logic [7:0]  count;
        logic        sat;
    } res_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_a;
    logic [14:0] in_b;
    logic        in_last;
    logic        mul_ce;
    logic [14:0] mul_din0;
    logic [14:0] mul_din1;
    logic [14:0] mul_dout;
    logic        out_valid;
    logic        out_ready;
    logic [14:0] out_data;
    logic [7:0]  out_count;
    logic        out_sat;

    int checks = 0;
    int passed = 0;
    bit drv_to = 1'b0;

    res_t obs_q[$];
    res_t exp_q[$];

    always #5 clk = ~clk;

    bgd_dot_accum dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .mul_ce    (mul_ce),
        .mul_din0  (mul_din0),
        .mul_din1  (mul_din1),
        .mul_dout  (mul_dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_sat   (out_sat)
    );

    // 3-stage ce-gated multiplier, low 15 bits of the product, data regs not reset
    logic signed [29:0] w_mp;
    logic [14:0]        r_m1, r_m2, r_m3;
    assign w_mp = $signed(mul_din0) * $signed(mul_din1);
    always @(posedge clk) begin
        if (mul_ce) begin
            r_m1 <= w_mp[14:0];
            r_m2 <= r_m1;
            r_m3 <= r_m2;
        end
    end
    assign mul_dout = r_m3;

    function automatic longint wrap_bits(input longint v, input int bits);
        longint m = longint'(1) << bits;
        longint r = v & (m - 1);
        if (r >= (m >>> 1)) r -= m;
        return r;
    endfunction

    function automatic res_t make_res(input longint s, input int n);
        res_t r;
        r.count = 8'(n);
        r.sat   = 1'b1;
        if (s > 16383)       r.data = 15'h3FFF;
        else if (s < -16384) r.data = 15'h4000;
        else begin
            r.data = 15'(s);
            r.sat  = 1'b0;
        end
        return r;
    endfunction

    // Reference: running sum of accepted pairs, result emitted on each last pair
    longint m_acc = 0;
    int     m_cnt = 0;
    longint m_p;
    res_t   m_obs;
    always @(negedge clk) begin
        if (reset) begin
            m_acc = 0;
            m_cnt = 0;
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                m_obs.data  = out_data;
                m_obs.count = out_count;
                m_obs.sat   = out_sat;
                obs_q.push_back(m_obs);
            end
            if (in_valid && in_ready) begin
                m_p   = wrap_bits(longint'($signed(in_a)) * longint'($signed(in_b)), 15);
                m_acc = wrap_bits(m_acc + m_p, 24);
                m_cnt++;
                if (in_last) begin
                    exp_q.push_back(make_res(m_acc, m_cnt));
                    m_acc = 0;
                    m_cnt = 0;
                end
            end
        end
    end

    task automatic send_pair(input int a, input int b, input bit last);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_a     = 15'(a);
        in_b     = 15'(b);
        in_last  = last;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) drv_to = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_obs(input int n, output bit ok);
        in_valid = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (obs_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic clear_queues;
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset;
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks += 6;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b want 0", out_valid); else passed++;
        if (out_data !== 15'd0) $display("FAIL reset_out_data: got %0d want 0", out_data); else passed++;
        if (out_count !== 8'd0) $display("FAIL reset_out_count: got %0d want 0", out_count); else passed++;
        if (out_sat !== 1'b0) $display("FAIL reset_out_sat: got %0b want 0", out_sat); else passed++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %0b want 1", in_ready); else passed++;
        if (mul_ce !== 1'b1) $display("FAIL reset_mul_ce: got %0b want 1", mul_ce); else passed++;
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int  lat = 0;
        bit  ok;
        clear_queues();
        out_ready = 1'b1;
        send_pair(3, 4, 1'b0);
        send_pair(-2, 5, 1'b0);
        send_pair(7, 1, 1'b1);
        in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        checks++;
        if (lat !== 3) $display("FAIL basic_latency: got %0d cycles want 3", lat); else passed++;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL basic_single_pulse: out_valid got %0b want 0", out_valid); else passed++;
        wait_obs(1, ok);
        checks++;
        if (!ok || obs_q.size() != 1) $display("FAIL basic_result_count: got %0d want 1", obs_q.size()); else passed++;
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0] !== res_t'({15'd9, 8'd3, 1'b0}))
                $display("FAIL basic_result: got data=%0d count=%0d sat=%0b want data=9 count=3 sat=0",
                         $signed(obs_q[0].data), obs_q[0].count, obs_q[0].sat);
            else passed++;
        end
    endtask

    task automatic test_saturation;
        bit ok;
        clear_queues();
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) send_pair(127, 127, i == 3);
        for (int i = 0; i < 4; i++) send_pair(-128, 127, i == 3);
        wait_obs(2, ok);
        idle(5);
        checks++;
        if (!ok || obs_q.size() != 2) $display("FAIL sat_result_count: got %0d want 2", obs_q.size()); else passed++;
        if (obs_q.size() > 1) begin
            checks += 2;
            if (obs_q[0] !== res_t'({15'h3FFF, 8'd4, 1'b1}))
                $display("FAIL sat_positive: got data=%0d count=%0d sat=%0b want data=16383 count=4 sat=1",
                         $signed(obs_q[0].data), obs_q[0].count, obs_q[0].sat);
            else passed++;
            if (obs_q[1] !== res_t'({15'h4000, 8'd4, 1'b1}))
                $display("FAIL sat_negative: got data=%0d count=%0d sat=%0b want data=-16384 count=4 sat=1",
                         $signed(obs_q[1].data), obs_q[1].count, obs_q[1].sat);
            else passed++;
        end
    endtask

    task automatic test_stall;
        bit ok;
        clear_queues();
        out_ready = 1'b0;
        fork
            begin
                send_pair(1, 2, 1'b0);
                send_pair(3, 4, 1'b1);
                send_pair(5, 6, 1'b0);
                send_pair(7, 8, 1'b0);
                send_pair(1, 1, 1'b1);
                in_valid = 1'b0;
            end
            begin
                for (int k = 0; k < 50; k++) begin
                    if (out_valid) break;
                    @(posedge clk); #1;
                end
                checks++;
                if (out_valid !== 1'b1) $display("FAIL stall_first_result: out_valid got %0b want 1", out_valid); else passed++;
                repeat (5) begin
                    checks += 3;
                    if (mul_ce !== 1'b0) $display("FAIL stall_mul_ce: got %0b want 0", mul_ce); else passed++;
                    if (in_ready !== 1'b0) $display("FAIL stall_in_ready: got %0b want 0", in_ready); else passed++;
                    if (out_data !== 15'd14) $display("FAIL stall_hold_data: got %0d want 14", out_data); else passed++;
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        join
        wait_obs(2, ok);
        idle(8);
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) $display("FAIL stall_result_count: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL stall_result[%0d]: got data=%0d count=%0d sat=%0b want data=%0d count=%0d sat=%0b", i,
                         $signed(obs_q[i].data), obs_q[i].count, obs_q[i].sat,
                         $signed(exp_q[i].data), exp_q[i].count, exp_q[i].sat);
            else passed++;
        end
        if (obs_q.size() > 1) begin
            checks++;
            if (obs_q[1] !== res_t'({15'd87, 8'd3, 1'b0}))
                $display("FAIL stall_second_value: got data=%0d count=%0d want data=87 count=3",
                         $signed(obs_q[1].data), obs_q[1].count);
            else passed++;
        end
    endtask

    task automatic test_back_to_back;
        bit ok = 1'b0;
        clear_queues();
        out_ready = 1'b1;
        send_pair(2, 3, 1'b1);
        send_pair(4, 5, 1'b1);
        in_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        checks += 3;
        if (!ok) $display("FAIL b2b_first_valid: out_valid got 0 want 1"); else passed++;
        if (out_data !== 15'd6) $display("FAIL b2b_first_data: got %0d want 6", out_data); else passed++;
        if (out_count !== 8'd1) $display("FAIL b2b_first_count: got %0d want 1", out_count); else passed++;
        @(posedge clk); #1;
        checks += 3;
        if (out_valid !== 1'b1) $display("FAIL b2b_second_valid: got %0b want 1", out_valid); else passed++;
        if (out_data !== 15'd20) $display("FAIL b2b_second_data: got %0d want 20", out_data); else passed++;
        if (out_count !== 8'd1) $display("FAIL b2b_second_count: got %0d want 1", out_count); else passed++;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL b2b_drop_valid: got %0b want 0", out_valid); else passed++;
    endtask

    task automatic test_reset_mid;
        bit ok;
        clear_queues();
        out_ready = 1'b1;
        send_pair(10, 10, 1'b0);
        send_pair(1, 1, 1'b0);
        reset = 1'b1;
        in_a = 15'd9; in_b = 15'd9; in_last = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        send_pair(2, 2, 1'b1);
        wait_obs(1, ok);
        idle(10);
        checks++;
        if (!ok || obs_q.size() != 1) $display("FAIL rstmid_result_count: got %0d want 1", obs_q.size()); else passed++;
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0] !== res_t'({15'd4, 8'd1, 1'b0}))
                $display("FAIL rstmid_result: got data=%0d count=%0d sat=%0b want data=4 count=1 sat=0",
                         $signed(obs_q[0].data), obs_q[0].count, obs_q[0].sat);
            else passed++;
        end
    endtask

    task automatic test_gaps;
        bit ok;
        clear_queues();
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            send_pair(1, 1, i == 5);
            idle(1);
        end
        wait_obs(1, ok);
        idle(10);
        checks++;
        if (!ok || obs_q.size() != 1) $display("FAIL gaps_pulse_count: got %0d want 1", obs_q.size()); else passed++;
        if (obs_q.size() > 0) begin
            checks++;
            if (obs_q[0] !== res_t'({15'd6, 8'd6, 1'b0}))
                $display("FAIL gaps_result: got data=%0d count=%0d sat=%0b want data=6 count=6 sat=0",
                         $signed(obs_q[0].data), obs_q[0].count, obs_q[0].sat);
            else passed++;
        end
    endtask

    task automatic test_random;
        bit ok;
        bit stop = 1'b0;
        clear_queues();
        fork
            begin
                for (int v = 0; v < 30; v++) begin
                    int len, lim;
                    len = int'($urandom_range(1, 6));
                    lim = ($urandom_range(0, 1) == 1) ? 16383 : 100;
                    for (int t = 0; t < len; t++) begin
                        send_pair(int'($urandom_range(0, 2 * lim)) - lim,
                                  int'($urandom_range(0, 2 * lim)) - lim, t == len - 1);
                        if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
                    end
                end
                in_valid = 1'b0;
                stop = 1'b1;
            end
            begin
                while (!stop) begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk); #1;
                end
            end
        join
        out_ready = 1'b1;
        wait_obs(exp_q.size(), ok);
        idle(8);
        checks++;
        if (!ok || obs_q.size() != exp_q.size()) $display("FAIL rand_result_count: got %0d want %0d", obs_q.size(), exp_q.size()); else passed++;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i])
                $display("FAIL rand_result[%0d]: got data=%0d count=%0d sat=%0b want data=%0d count=%0d sat=%0b", i,
                         $signed(obs_q[i].data), obs_q[i].count, obs_q[i].sat,
                         $signed(exp_q[i].data), exp_q[i].count, exp_q[i].sat);
            else passed++;
        end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_saturation();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_gaps();
        test_random();
        checks++;
        if (drv_to) $display("FAIL drive_handshake: a pair was never accepted within the cycle budget"); else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
